// File: rtl/collatz_pkg.sv
// Shared constants for the inverse Collatz walker: FSM encoding, error codes, default width.
// Pure declarations; no logic, no latency, no flow control.
package collatz_pkg;

  localparam int W_DEFAULT = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ODD  = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

endpackage

// File: rtl/collatz_inv_step.sv
// One inverse Collatz step: code 0 un-halves (2n), code 1 un-triples ((n-1)/3), plus validity flags.
// Purely combinational, zero latency; no flow control.
module collatz_inv_step
  import collatz_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] n,
  input  logic         code,
  output logic [W-1:0] next_n,
  output logic         odd_ok,
  output logic         ovf
);

  always_comb begin
    next_n = code ? ((n - W'(1)) / W'(3)) : {n[W-2:0], 1'b0};
    // n = 4 would un-triple to 1, which is the loop, not a real predecessor
    odd_ok = ((n % W'(6)) == W'(4)) && (n != W'(4));
    ovf    = n[W-1];
  end

endmodule

// File: rtl/collatz_inverse.sv
// Reverse Collatz walker: applies up to MAXLEN programmed inverse steps to a seed, one per clock.
// Latency len+1 cycles from accepted start to done (k+2 on an error at step k); start ignored unless idle.
// Checks for bad odd steps and overflow are built only with COLLATZ_INV_CHECK_EN defined.
module collatz_inverse
  import collatz_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int MAXLEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      seed,
  input  logic [MAXLEN-1:0] path,
  input  logic [3:0]        len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [W-1:0]      n_out,
  output logic [3:0]        steps
);

  logic [1:0]        state;
  logic [MAXLEN-1:0] path_q;
  logic [3:0]        len_q;
  logic [3:0]        len_clamped;
  logic [W-1:0]      next_n;

  assign len_clamped = (len > 4'(MAXLEN)) ? 4'(MAXLEN) : len;

`ifdef COLLATZ_INV_CHECK_EN
  logic       odd_ok;
  logic       ovf;
  logic       err_q;
  logic [1:0] err_code_q;

  collatz_inv_step #(.W(W)) u_step (
    .n      (n_out),
    .code   (path_q[0]),
    .next_n (next_n),
    .odd_ok (odd_ok),
    .ovf    (ovf)
  );

  assign err      = err_q;
  assign err_code = err_code_q;
`else
  collatz_inv_step #(.W(W)) u_step (
    .n      (n_out),
    .code   (path_q[0]),
    .next_n (next_n),
    .odd_ok (),
    .ovf    ()
  );

  assign err      = 1'b0;
  assign err_code = ERR_NONE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      n_out  <= '0;
      steps  <= '0;
      path_q <= '0;
      len_q  <= '0;
`ifdef COLLATZ_INV_CHECK_EN
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_out  <= seed;
            path_q <= path;
            len_q  <= len_clamped;
            steps  <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
`ifdef COLLATZ_INV_CHECK_EN
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
`endif
          end
        end

        ST_RUN: begin
`ifdef COLLATZ_INV_CHECK_EN
          // A flagged step spends one more cycle in RUN before DONE
          if (err_q || (steps == len_q)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!path_q[0] && ovf) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_OVF;
          end else if (path_q[0] && !odd_ok) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_ODD;
          end else begin
            n_out  <= next_n;
            steps  <= steps + 4'd1;
            path_q <= path_q >> 1;
          end
`else
          if (steps == len_q) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            n_out  <= next_n;
            steps  <= steps + 4'd1;
            path_q <= path_q >> 1;
          end
`endif
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/collatz_inverse.md
# collatz_inverse

Reverse-walks the Collatz map: starting from a seed value, applies a programmed sequence of inverse steps (un-halve or un-triple) to reconstruct the predecessor value, one step per clock. It is the decoder counterpart of the forward Collatz iteration counter. Its output N, fed into the forward counter, reproduces the seed after the same number of steps. It sits beside the forward engine and generates test inputs and tree-walk values for it.

## Interface
- W, 16: datapath width of seed and result.
- MAXLEN, 8: maximum path length; path width equals MAXLEN.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- seed  in  W  starting value, captured on accepted start.
- path  in  MAXLEN  step codes, bit k applied at step k (LSB first); 0 = inverse even, 1 = inverse odd.
- len  in  4  number of steps to apply; values > MAXLEN clamp to MAXLEN.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on completion or error.
- err  out  1  result invalid; held until next accepted start.
- err_code  out  2  00 none, 01 invalid odd step, 10 overflow.
- n_out  out  W  current/final value; held after done.
- steps  out  4  steps successfully applied.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on start=1, latch seed→n_out, path, clamped len. Clear steps, err and err_code. Go to RUN.
- RUN, steps==len: go to DONE.
- RUN, code 0: n ← 2n. With the check enabled, n[W-1]=1 is an overflow: err=1, code 10, n unchanged, go to DONE.
- RUN, code 1: valid only if n mod 6 == 4 and n != 4; then n ← (n−1)/3. Otherwise err=1, code 01, n unchanged, go to DONE.
- On a successful step: steps += 1, stay in RUN.
- DONE: done=1 for exactly one cycle, then IDLE.
- start while not IDLE is ignored; it is not queued.
- Reset values: state IDLE; busy, done, err = 0; err_code, n_out, steps = 0.
- Reset mid-operation aborts immediately. No done pulse is generated.
- Arithmetic is unsigned W-bit. The divide by 3 is exact by construction when valid.

## Timing
- Start sampled at edge t (IDLE). RUN begins after edge t with n_out=seed.
- One step per edge. DONE is entered at edge t+len+1 on success, or at edge t+k+2 on an error at step k.
- done is high during the cycle after entering DONE. busy falls on the same edge.
- len=0: done is high in the cycle after edge t+1, with n_out=seed.
- Earliest next accepted start is the edge following the done cycle.
- Outputs are registered and have no combinational input-to-output paths.

## Configuration
- COLLATZ_INV_CHECK_EN defined: odd-step validity and overflow checks are active, as described above.
- COLLATZ_INV_CHECK_EN undefined: no checks. err and err_code are tied 0. Code 0 wraps modulo 2^W. Code 1 computes truncated (n−1)/3, with 0−1 wrapping. The run always completes len steps, so latency is always len+1.

## Structure
- Shared package collatz_pkg holds:
  - the state encoding (IDLE, RUN, DONE);
  - err_code constants ERR_NONE, ERR_ODD, ERR_OVF;
  - the default W.
- One combinational sub-module, collatz_inv_step. It takes n and code and returns next_n, odd_ok and ovf. The top level holds the FSM, counter and registers.

## Test plan
- seed=1, len=4, path=0x00 → n_out=16, steps=4, err=0, done in the cycle after edge t+5.
- seed=1, len=6, path=0x10 (sequence 1,2,4,8,16,5,10) → n_out=10, steps=6, err=0.
- seed=1, len=3, path=0x04 (odd step at n=4) → err=1, err_code=01, n_out=4, steps=2, single done pulse.
- seed=0x8000, len=1, path=0x00 → err=1, err_code=10, n_out=0x8000. Without the macro: n_out=0, err=0.
- len=0, seed=7 → done in the cycle after edge t+1, n_out=7. A start pulse asserted during a run is ignored: no second done.
- rst asserted during RUN (seed=1, len=8) → busy, done, n_out and steps are 0 immediately. A start after reset release completes normally.
